// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC result path: TOF value format, output word layout
// and the reader FSM encoding.
package tdc_pkg;

  localparam int TOF_W = 15;
  localparam int WORD_W = 16;
  localparam logic [TOF_W-1:0] TOF_OOR = 15'h7FFF;
  localparam logic [3:0] HDR_TAG = 4'hA;

  // Word field offsets
  localparam int HIT_RANGE_BIT = 15;
  localparam int HDR_TAG_LSB = 12;
  localparam int HDR_ID_LSB = 4;
  localparam int HDR_TMO_BIT = 2;
  localparam int HDR_NHITS_LSB = 0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    COLLECT    = 2'd2,
    COMMIT     = 2'd3
  } state_e;

  function automatic logic [WORD_W-1:0] hit_word(input logic [TOF_W-1:0] tof);
    logic [WORD_W-1:0] w;
    w = '0;
    w[TOF_W-1:0] = tof;
    w[HIT_RANGE_BIT] = (tof != TOF_OOR);
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] hdr_word(input logic [7:0] id, input logic tmo,
                                                 input logic [1:0] nhits);
    logic [WORD_W-1:0] w;
    w = '0;
    w[HDR_TAG_LSB +: 4] = HDR_TAG;
    w[HDR_ID_LSB +: 8] = id;
    w[HDR_TMO_BIT] = tmo;
    w[HDR_NHITS_LSB +: 2] = nhits;
    return w;
  endfunction

endpackage

// File: rtl/tof_word_fifo.sv
// Show-ahead word FIFO with occupancy output; pointers carry an extra wrap bit.
module tof_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic empty, full, do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Stale memory is masked so the head reads as zero while empty
  assign rdata = empty ? '0 : mem[rptr_q[AW-1:0]];
  assign valid = !empty;
  assign level = wptr_q - rptr_q;

endmodule

// File: rtl/tof_result_reader.sv
// Groups per-trigger TDC stop results into header+hit frames and commits them
// into a show-ahead word FIFO, dropping whole frames when space is short.
module tof_result_reader
  import tdc_pkg::*;
#(
  parameter int MAX_HITS = 3,
  parameter int DEPTH    = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tri_en,
  input  logic                   out_valid,
  input  logic [TOF_W-1:0]       tof_data_in,
  output logic [WORD_W-1:0]      rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             drop_cnt,
  output logic                   busy
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] LAST_IDX = 2'(MAX_HITS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e state_q, state_d;
  logic [TMR_W-1:0] timer_q;
  logic [1:0] nhits_q, widx_q;
  logic [TOF_W-1:0] hit_q [0:3];
  logic timeout_flag_q, pending_q;
  logic [7:0] frame_id_q;

  logic timer_exp, timer_reload, store, close, close_by_timer;
  logic space_ok, push, commit_done, drop;
  logic [WORD_W-1:0] push_word;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign timer_exp    = (timer_q == TMR_LAST) && !out_valid && !tri_en;
  assign timer_reload = out_valid || tri_en || (state_q == IDLE) || (state_q == COMMIT);
  assign space_ok     = (DEPTH - int'(fifo_level)) >= (int'(nhits_q) + 1);

  always_comb begin
    state_d        = state_q;
    store          = 1'b0;
    close          = 1'b0;
    close_by_timer = 1'b0;
    push           = 1'b0;
    push_word      = '0;
    commit_done    = 1'b0;
    drop           = 1'b0;
    case (state_q)
      IDLE: if (tri_en) state_d = WAIT_START;
      WAIT_START: begin
        // tri_en restarts the wait; the start strobe itself carries no data
        if (tri_en) state_d = WAIT_START;
        else if (out_valid) state_d = COLLECT;
        else if (timer_exp) begin
          close = 1'b1;
          close_by_timer = 1'b1;
        end
      end
      COLLECT: begin
        store = out_valid;
        if ((out_valid && nhits_q == LAST_IDX) || tri_en) close = 1'b1;
        else if (timer_exp) begin
          close = 1'b1;
          close_by_timer = 1'b1;
        end
      end
      COMMIT: begin
        if (widx_q == 2'd0) begin
          if (space_ok) begin
            push        = 1'b1;
            push_word   = hdr_word(frame_id_q, timeout_flag_q, nhits_q);
            commit_done = (nhits_q == 2'd0);
          end else begin
            drop        = 1'b1;
            commit_done = 1'b1;
          end
        end else begin
          push        = 1'b1;
          push_word   = hit_word(hit_q[widx_q - 2'd1]);
          commit_done = (widx_q == nhits_q);
        end
        if (commit_done) state_d = (pending_q || tri_en) ? WAIT_START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (close) state_d = COMMIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      nhits_q        <= '0;
      widx_q         <= '0;
      timeout_flag_q <= 1'b0;
      pending_q      <= 1'b0;
      frame_id_q     <= '0;
      drop_cnt       <= '0;
      for (int i = 0; i < 4; i++) hit_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (timer_reload) timer_q <= '0;
      else if (timer_q != TMR_LAST) timer_q <= timer_q + TMR_W'(1);
      if (state_q == IDLE || state_q == WAIT_START) nhits_q <= '0;
      else if (store) begin
        hit_q[nhits_q] <= tof_data_in;
        nhits_q        <= nhits_q + 2'd1;
      end
      if (close) timeout_flag_q <= close_by_timer;
      widx_q <= (state_q == COMMIT && !commit_done) ? widx_q + 2'd1 : 2'd0;
      // A trigger that lands while a frame is still open re-arms once the commit ends
      if (state_q == COMMIT && commit_done) pending_q <= 1'b0;
      else if (tri_en && (state_q == COLLECT || state_q == COMMIT)) pending_q <= 1'b1;
      if (commit_done) frame_id_q <= frame_id_q + 8'd1;
      if (drop) drop_cnt <= sat_inc8(drop_cnt);
    end
  end

  assign busy = (state_q != IDLE);

  tof_word_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_word),
    .pop   (rd_ready),
    .rdata (rd_data),
    .valid (rd_valid),
    .level (fifo_level)
  );

endmodule
